// File: rtl/scarv_cop_rsp_queue_if.sv
// ----------------------------------------------------------------------------
// scarv_cop_rsp_queue_if
//   Bundles the two channels of the coprocessor return path:
//     - completion channel from the execute stage (ex_*), back-pressured by
//       ex_stall
//     - valid/ready response channel towards the host CPU (cpu_rsp_*)
//   Modports:
//     master : the response queue (consumes ex_*, drives cpu_rsp_*)
//     slave  : the surrounding environment (execute stage + CPU)
// ----------------------------------------------------------------------------
interface scarv_cop_rsp_queue_if;

    // Completion channel from execute
    logic        ex_done;
    logic        ex_stall;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_wb;
    logic        ex_exception;
    logic [2:0]  ex_cause;

    // Response channel to the host CPU
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready;
    logic [31:0] cpu_rsp_data;
    logic [4:0]  cpu_rsp_rd;
    logic        cpu_rsp_wen;
    logic        cpu_rsp_error;

    modport master (
        input  ex_done,
        input  ex_result,
        input  ex_rd,
        input  ex_wb,
        input  ex_exception,
        input  ex_cause,
        output ex_stall,
        output cpu_rsp_valid,
        input  cpu_rsp_ready,
        output cpu_rsp_data,
        output cpu_rsp_rd,
        output cpu_rsp_wen,
        output cpu_rsp_error
    );

    modport slave (
        output ex_done,
        output ex_result,
        output ex_rd,
        output ex_wb,
        output ex_exception,
        output ex_cause,
        input  ex_stall,
        input  cpu_rsp_valid,
        output cpu_rsp_ready,
        input  cpu_rsp_data,
        input  cpu_rsp_rd,
        input  cpu_rsp_wen,
        input  cpu_rsp_error
    );

endinterface

// File: rtl/scarv_cop_rsp_queue.sv
// ----------------------------------------------------------------------------
// scarv_cop_rsp_queue
//   Return path of the coprocessor/CPU interface. Each finished ISE
//   instruction hands one completion record (result, GPR target, exception
//   flag) to this queue; records are kept in completion order in a circular
//   buffer and offered to the host CPU on a valid/ready channel.
//
//   Ports:
//     g_clk      : core clock, all state updates on the rising edge
//     g_resetn   : asynchronous active-low reset
//     flush      : synchronous discard of every buffered response
//     rsp_count  : current occupancy (0..DEPTH)
//     rsp        : completion + response channels (master modport)
//
//   Parameters:
//     DEPTH      : number of buffered responses, power of two, >= 2
// ----------------------------------------------------------------------------
module scarv_cop_rsp_queue #(
    parameter int DEPTH = 2
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  rsp_count,
    scarv_cop_rsp_queue_if.master   rsp
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        error;
    } entry_t;

    // An exception replaces the result with the zero-extended cause code and
    // suppresses the writeback; a write to x0 is never requested either.
    function automatic entry_t form_entry(
        input logic [31:0] result,
        input logic [4:0]  rd,
        input logic        wb,
        input logic        exception,
        input logic [2:0]  cause
    );
        entry_t e;
        e.error = exception;
        e.wen   = wb & ~exception & (rd != 5'd0);
        e.data  = exception ? {29'b0, cause} : result;
        e.rd    = rd;
        return e;
    endfunction

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             valid;
    logic             push;
    logic             pop;
    entry_t           head;

    // Stall comes from registered occupancy only, so a full queue refuses a
    // push even in a cycle where the CPU pops.
    assign full  = (count == FULL);
    assign valid = (count != '0);
    assign push  = rsp.ex_done & ~full;
    assign pop   = valid & rsp.cpu_rsp_ready;

    // Control state: occupancy and the two wrapping pointers. Pointer width
    // is exactly log2(DEPTH), so natural overflow performs the wrap.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: an entry is only observable once count says
    // it was written, and outputs are masked while the queue is empty.
    always_ff @(posedge g_clk) begin
        if (push) begin
            mem[wr_ptr] <= form_entry(rsp.ex_result, rsp.ex_rd, rsp.ex_wb,
                                      rsp.ex_exception, rsp.ex_cause);
        end
    end

    assign head = mem[rd_ptr];

    assign rsp.ex_stall      = full;
    assign rsp.cpu_rsp_valid = valid;
    assign rsp.cpu_rsp_data  = valid ? head.data  : 32'd0;
    assign rsp.cpu_rsp_rd    = valid ? head.rd    : 5'd0;
    assign rsp.cpu_rsp_wen   = valid ? head.wen   : 1'b0;
    assign rsp.cpu_rsp_error = valid ? head.error : 1'b0;
    assign rsp_count         = count;

    a_count_bound: assert property (
        @(posedge g_clk) disable iff (!g_resetn) count <= FULL
    );

    a_no_underflow: assert property (
        @(posedge g_clk) disable iff (!g_resetn) !(pop && (count == '0))
    );

endmodule

// File: tb/tb_scarv_cop_rsp_queue.sv
// ----------------------------------------------------------------------------
// tb_scarv_cop_rsp_queue
//   Scenario bench for the coprocessor response queue. A queue of expected
//   responses is filled when a record is accepted and consumed when the CPU
//   pops, and each scenario task compares the DUT against it (and against
//   hand-written constants for the directed cases).
// ----------------------------------------------------------------------------
module tb_scarv_cop_rsp_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        err;
    } rsp_t;

    logic             g_clk    = 1'b0;
    logic             g_resetn = 1'b0;
    logic             flush    = 1'b0;
    logic [CNT_W-1:0] rsp_count;

    scarv_cop_rsp_queue_if rif ();

    scarv_cop_rsp_queue #(.DEPTH(DEPTH)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .rsp_count (rsp_count),
        .rsp       (rif)
    );

    always #5 g_clk = ~g_clk;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic rsp_t model_entry(input logic [31:0] res, input logic [4:0] rd,
                                         input logic wb, input logic exc, input logic [2:0] cause);
        rsp_t e;
        e.err  = exc;
        e.wen  = wb && !exc && (rd != 5'd0);
        e.data = exc ? {29'b0, cause} : res;
        e.rd   = rd;
        return e;
    endfunction

    function automatic rsp_t dut_head();
        return {rif.cpu_rsp_data, rif.cpu_rsp_rd, rif.cpu_rsp_wen, rif.cpu_rsp_error};
    endfunction

    function automatic rsp_t exp_head();
        if (exp_q.size() == 0) return '0;
        return exp_q[0];
    endfunction

    task automatic set_ex(input logic done, input logic [31:0] res, input logic [4:0] rd,
                          input logic wb, input logic exc, input logic [2:0] cause);
        rif.ex_done      = done;
        rif.ex_result    = res;
        rif.ex_rd        = rd;
        rif.ex_wb        = wb;
        rif.ex_exception = exc;
        rif.ex_cause     = cause;
    endtask

    // Advance one clock and update the scoreboard from the inputs that were
    // applied during the cycle. Leaves time at posedge+1.
    task automatic tick();
        logic do_push, do_pop, do_flush;
        rsp_t e;
        do_flush = flush;
        do_push  = rif.ex_done && (exp_q.size() < DEPTH);
        do_pop   = (exp_q.size() != 0) && rif.cpu_rsp_ready;
        e = model_entry(rif.ex_result, rif.ex_rd, rif.ex_wb, rif.ex_exception, rif.ex_cause);
        @(posedge g_clk);
        if (do_flush) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        rsp_t zero = '0;
        g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        n_checks++; if (rif.cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", rif.cpu_rsp_valid); end
        n_checks++; if (rif.ex_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", rif.ex_stall); end
        n_checks++; if (rsp_count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rsp_count); end
        n_checks++; if (dut_head() !== zero) begin n_fail++; $display("FAIL reset_payload: got %h want %h", dut_head(), zero); end
        g_resetn = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic test_single();
        rsp_t want = {32'hDEADBEEF, 5'd5, 1'b1, 1'b0};
        rif.cpu_rsp_ready = 1'b1;
        set_ex(1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 3'd0);
        n_checks++; if (rif.cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %0b want 0", rif.cpu_rsp_valid); end
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rif.cpu_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", rif.cpu_rsp_valid); end
        n_checks++; if (dut_head() !== want) begin n_fail++; $display("FAIL single_payload: got %h want %h", dut_head(), want); end
        n_checks++; if (rsp_count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_count1: got %0d want 1", rsp_count); end
        tick();
        n_checks++; if (rsp_count !== CNT_W'(0)) begin n_fail++; $display("FAIL single_count0: got %0d want 0", rsp_count); end
        n_checks++; if (rif.cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %0b want 0", rif.cpu_rsp_valid); end
    endtask

    task automatic test_fill();
        rif.cpu_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 32'hA000_0000 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 3'd0);
            n_checks++;
            if (rif.ex_stall !== (exp_q.size() == DEPTH)) begin
                n_fail++; $display("FAIL fill_stall_%0d: got %0b want %0b", i, rif.ex_stall, exp_q.size() == DEPTH);
            end
            tick();
        end
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rsp_count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL fill_count_full: got %0d want %0d", rsp_count, DEPTH); end
        n_checks++; if (rif.ex_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall_full: got %0b want 1", rif.ex_stall); end
        // Push and pop together while full: the push must be refused.
        rif.cpu_rsp_ready = 1'b1;
        set_ex(1'b1, 32'hB000_0000, 5'd9, 1'b1, 1'b0, 3'd0);
        n_checks++; if (dut_head().data !== 32'hA000_0000) begin n_fail++; $display("FAIL fill_order0: got %h want a0000000", dut_head().data); end
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rsp_count !== CNT_W'(1)) begin n_fail++; $display("FAIL fill_blocked_push: got count %0d want 1", rsp_count); end
        n_checks++; if (rif.ex_stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall_drop: got %0b want 0", rif.ex_stall); end
        n_checks++; if (dut_head() !== exp_head() || dut_head().data !== 32'hA000_0001) begin
            n_fail++; $display("FAIL fill_order1: got %h want %h", dut_head(), exp_head());
        end
        tick();
        n_checks++; if (rif.cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %0b want 0", rif.cpu_rsp_valid); end
    endtask

    task automatic test_exception();
        rsp_t want = {32'h0000_0003, 5'd7, 1'b0, 1'b1};
        rif.cpu_rsp_ready = 1'b1;
        set_ex(1'b1, 32'h0000_1234, 5'd7, 1'b1, 1'b1, 3'd3);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rif.cpu_rsp_valid !== 1'b1 || dut_head() !== want) begin
            n_fail++; $display("FAIL exception_rsp: got v=%0b %h want v=1 %h", rif.cpu_rsp_valid, dut_head(), want);
        end
        tick();
    endtask

    task automatic test_x0_write();
        rsp_t want = {32'hCAFE_F00D, 5'd0, 1'b0, 1'b0};
        rif.cpu_rsp_ready = 1'b1;
        set_ex(1'b1, 32'hCAFE_F00D, 5'd0, 1'b1, 1'b0, 3'd5);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rif.cpu_rsp_valid !== 1'b1 || dut_head() !== want) begin
            n_fail++; $display("FAIL x0_rsp: got v=%0b %h want v=1 %h", rif.cpu_rsp_valid, dut_head(), want);
        end
        tick();
    endtask

    task automatic test_stream();
        rif.cpu_rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_ex(1'b1, 32'h100 + 32'(i), 5'((i % 31) + 1), i[0], 1'b0, 3'd0);
            if (i > 0) begin
                n_checks++;
                if (rif.cpu_rsp_valid !== 1'b1 || rsp_count !== CNT_W'(1) ||
                    dut_head() !== exp_head() || dut_head().data !== 32'h100 + 32'(i - 1)) begin
                    n_fail++;
                    $display("FAIL stream_%0d: got v=%0b cnt=%0d %h want v=1 cnt=1 %h",
                             i, rif.cpu_rsp_valid, rsp_count, dut_head(), exp_head());
                end
            end
            tick();
        end
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (dut_head() !== exp_head() || dut_head().data !== 32'h113) begin
            n_fail++; $display("FAIL stream_last: got %h want %h", dut_head(), exp_head());
        end
        tick();
        n_checks++; if (rif.cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %0b want 0", rif.cpu_rsp_valid); end
    endtask

    task automatic test_flush();
        rsp_t want;
        rif.cpu_rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_ex(1'b1, 32'hD000_0000 + 32'(i), 5'd4, 1'b1, 1'b0, 3'd0);
            tick();
        end
        flush = 1'b1;
        set_ex(1'b1, 32'hF100_0000, 5'd6, 1'b1, 1'b0, 3'd0);
        tick();
        flush = 1'b0;
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rsp_count !== CNT_W'(0) || rif.cpu_rsp_valid !== 1'b0 || rif.ex_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_full: got cnt=%0d v=%0b stall=%0b want 0 0 0", rsp_count, rif.cpu_rsp_valid, rif.ex_stall);
        end
        // One queued, then flush together with a push and a pop.
        set_ex(1'b1, 32'hD100_0000, 5'd4, 1'b1, 1'b0, 3'd0);
        tick();
        flush = 1'b1;
        rif.cpu_rsp_ready = 1'b1;
        set_ex(1'b1, 32'hF200_0000, 5'd6, 1'b1, 1'b0, 3'd0);
        tick();
        flush = 1'b0;
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rsp_count !== CNT_W'(0) || rif.cpu_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_pushpop: got cnt=%0d v=%0b want 0 0", rsp_count, rif.cpu_rsp_valid);
        end
        rif.cpu_rsp_ready = 1'b0;
        set_ex(1'b1, 32'hE000_0001, 5'd12, 1'b1, 1'b0, 3'd0);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        want = {32'hE000_0001, 5'd12, 1'b1, 1'b0};
        n_checks++; if (rif.cpu_rsp_valid !== 1'b1 || dut_head() !== want || exp_head() !== want) begin
            n_fail++; $display("FAIL flush_next: got v=%0b %h want v=1 %h", rif.cpu_rsp_valid, dut_head(), want);
        end
        rif.cpu_rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_stream();
        rsp_t want = {32'h0000_5A5A, 5'd3, 1'b1, 1'b0};
        rsp_t zero = '0;
        rif.cpu_rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_ex(1'b1, 32'hC000_0000 + 32'(i), 5'd8, 1'b1, 1'b0, 3'd0);
            tick();
        end
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        #2 g_resetn = 1'b0;
        #1;
        n_checks++; if (rsp_count !== CNT_W'(0) || rif.cpu_rsp_valid !== 1'b0 || rif.ex_stall !== 1'b0 || dut_head() !== zero) begin
            n_fail++; $display("FAIL reset_async: got cnt=%0d v=%0b stall=%0b %h want all 0",
                               rsp_count, rif.cpu_rsp_valid, rif.ex_stall, dut_head());
        end
        exp_q.delete();
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        rif.cpu_rsp_ready = 1'b1;
        set_ex(1'b1, 32'h0000_5A5A, 5'd3, 1'b1, 1'b0, 3'd0);
        tick();
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        n_checks++; if (rif.cpu_rsp_valid !== 1'b1 || dut_head() !== want) begin
            n_fail++; $display("FAIL reset_next: got v=%0b %h want v=1 %h", rif.cpu_rsp_valid, dut_head(), want);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.cpu_rsp_ready = 1'b0;
        set_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
        test_reset();
        test_single();
        test_fill();
        test_exception();
        test_x0_write();
        test_stream();
        test_flush();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
